// File: rtl/video_timing_pattern.sv
// Video timing generator with built-in test patterns (bars, checker, gradient, white, bouncing box).
// Counters run from negative blanking coordinates through the active area; every output is registered.
module video_timing_pattern #(
  parameter int HRES      = 640,
  parameter int VRES      = 480,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COORDSPC  = 16,
  parameter int COLSPC    = 10,
  parameter int CHK_LOG2  = 5,
  parameter int BOX       = 32
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst_n,
  input  logic [2:0]                 mode,
  output logic                       video_enable,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_start,
  output logic                       line_start,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic [COLSPC-1:0]          red,
  output logic [COLSPC-1:0]          green,
  output logic [COLSPC-1:0]          blue,
  output logic [15:0]                frame_cnt
);

  localparam logic signed [COORDSPC-1:0] H_STA  = COORDSPC'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [COORDSPC-1:0] V_STA  = COORDSPC'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [COORDSPC-1:0] H_LAST = COORDSPC'(HRES - 1);
  localparam logic signed [COORDSPC-1:0] V_LAST = COORDSPC'(VRES - 1);
  // Sync windows sit right after the front porch, i.e. they end one back porch before zero.
  localparam logic signed [COORDSPC-1:0] HS_BEG = COORDSPC'(-(H_SYNC + H_BP));
  localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(-(H_BP + 1));
  localparam logic signed [COORDSPC-1:0] VS_BEG = COORDSPC'(-(V_SYNC + V_BP));
  localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(-(V_BP + 1));
  localparam logic signed [COORDSPC-1:0] BX_MAX = COORDSPC'(HRES - BOX);
  localparam logic signed [COORDSPC-1:0] BY_MAX = COORDSPC'(VRES - BOX);
  localparam logic signed [COORDSPC-1:0] BOX_M1 = COORDSPC'(BOX - 1);
  localparam logic signed [COORDSPC-1:0] ONE    = COORDSPC'(1);
  localparam int                         BAR_W  = HRES / 8;
  localparam logic [COLSPC-1:0]          CMAX   = '1;

  logic signed [COORDSPC-1:0] hc;
  logic signed [COORDSPC-1:0] vc;
  logic signed [COORDSPC-1:0] bx;
  logic signed [COORDSPC-1:0] by;
  logic                       bx_inc;
  logic                       by_inc;
  logic [2:0]                 mode_q;
  logic [15:0]                fcnt;

  logic                       h_last;
  logic                       v_last;
  logic                       at_origin;
  logic                       active;
  logic                       hs_act;
  logic                       vs_act;
  logic                       in_box;
  logic [2:0]                 bar_idx;
  logic [COORDSPC-1:0]        hc_u;
  logic [COLSPC-1:0]          red_n;
  logic [COLSPC-1:0]          green_n;
  logic [COLSPC-1:0]          blue_n;

  assign h_last    = (hc == H_LAST);
  assign v_last    = (vc == V_LAST);
  assign at_origin = (hc == H_STA) && (vc == V_STA);
  assign active    = !hc[COORDSPC-1] && !vc[COORDSPC-1];
  assign hs_act    = (hc >= HS_BEG) && (hc <= HS_END);
  assign vs_act    = (vc >= VS_BEG) && (vc <= VS_END);
  assign hc_u      = hc;

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      hc     <= H_STA;
      vc     <= V_STA;
      mode_q <= 3'd0;
      fcnt   <= 16'd0;
    end else begin
      if (h_last) begin
        hc <= H_STA;
        vc <= v_last ? V_STA : vc + ONE;
      end else begin
        hc <= hc + ONE;
      end
      if (at_origin) mode_q <= mode;
      if (h_last && v_last) fcnt <= fcnt + 16'd1;
    end
  end

  // Box moves once per frame on the wrap into the origin; a bounce reverses and steps in one go.
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      bx     <= '0;
      by     <= '0;
      bx_inc <= 1'b1;
      by_inc <= 1'b1;
    end else if (h_last && v_last) begin
      if (bx_inc) begin
        if (bx == BX_MAX) begin
          bx     <= bx - ONE;
          bx_inc <= 1'b0;
        end else begin
          bx <= bx + ONE;
        end
      end else if (bx == '0) begin
        bx     <= ONE;
        bx_inc <= 1'b1;
      end else begin
        bx <= bx - ONE;
      end
      if (by_inc) begin
        if (by == BY_MAX) begin
          by     <= by - ONE;
          by_inc <= 1'b0;
        end else begin
          by <= by + ONE;
        end
      end else if (by == '0) begin
        by     <= ONE;
        by_inc <= 1'b1;
      end else begin
        by <= by - ONE;
      end
    end
  end

  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hc_u >= COORDSPC'(k * BAR_W)) bar_idx = 3'(k);
    end
    in_box = (hc >= bx) && (hc <= bx + BOX_M1) && (vc >= by) && (vc <= by + BOX_M1);
    if (active) begin
      case (mode_q)
        3'd0: begin
          red_n   = {COLSPC{~bar_idx[1]}};
          green_n = {COLSPC{~bar_idx[2]}};
          blue_n  = {COLSPC{~bar_idx[0]}};
        end
        3'd1: begin
          red_n   = {COLSPC{hc[CHK_LOG2] ^ vc[CHK_LOG2]}};
          green_n = {COLSPC{hc[CHK_LOG2] ^ vc[CHK_LOG2]}};
          blue_n  = {COLSPC{hc[CHK_LOG2] ^ vc[CHK_LOG2]}};
        end
        3'd2: begin
          red_n   = hc[COLSPC-1:0];
          green_n = vc[COLSPC-1:0];
          blue_n  = fcnt[COLSPC-1:0];
        end
        3'd3: begin
          red_n   = CMAX;
          green_n = CMAX;
          blue_n  = CMAX;
        end
        3'd4: begin
          red_n   = in_box ? CMAX : '0;
          green_n = in_box ? CMAX : '0;
          blue_n  = CMAX;
        end
        default: begin
          red_n   = '0;
          green_n = '0;
          blue_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx           <= '0;
      sy           <= '0;
      video_enable <= 1'b0;
      frame_start  <= 1'b0;
      line_start   <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      frame_cnt    <= 16'd0;
    end else begin
      sx           <= hc;
      sy           <= vc;
      video_enable <= active;
      frame_start  <= at_origin;
      line_start   <= (hc == H_STA);
      hsync        <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync        <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      red          <= red_n;
      green        <= green_n;
      blue         <= blue_n;
      frame_cnt    <= fcnt;
    end
  end

endmodule

// File: doc/video_timing_pattern.md
VIDEO_TIMING_PATTERN -- requirements
Module: video_timing_pattern

Interface
REQ-001 Param HRES, default 640, active pixels per line (multiple of 8, >=16).
REQ-002 Param VRES, default 480, active lines per frame.
REQ-003 Params H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels (each >=1).
REQ-004 Params V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines (each >=1).
REQ-005 Params HSYNC_POL/VSYNC_POL, default 0/0, sync active level (1 = active-high).
REQ-006 Param COORDSPC, default 16, signed coordinate width; COLSPC, default 10, colour channel width.
REQ-007 Params CHK_LOG2, default 5, checker square size 2^CHK_LOG2; BOX, default 32, moving box edge in pixels (BOX < VRES).
REQ-008 video_clk_pix  in  1  pixel clock; all state on rising edge.
REQ-009 video_rst_n  in  1  asynchronous, active-low reset.
REQ-010 mode  in  3  pattern select, sampled only at frame origin.
REQ-011 video_enable/hsync/vsync/frame_start/line_start  out  1 each  data enable, syncs, one-cycle frame and line pulses.
REQ-012 sx, sy  out  COORDSPC signed  current coordinates; negative in blanking.
REQ-013 red, green, blue  out  COLSPC each  pixel colour.
REQ-014 frame_cnt  out  16  frame counter.

Function
REQ-015 Constants H_STA = -(H_FP+H_SYNC+H_BP), V_STA = -(V_FP+V_SYNC+V_BP); internal counters hc runs H_STA..HRES-1, vc runs V_STA..VRES-1.
REQ-016 hc increments every cycle; at HRES-1 it wraps to H_STA and vc advances; vc wraps VRES-1 -> V_STA together with hc wrap.
REQ-017 All outputs registered; every output reflects the counter value of the previous cycle (latency 1), colour aligned with the same sx/sy/video_enable.
REQ-018 video_enable = (hc>=0 && vc>=0); line_start = (hc==H_STA); frame_start = (hc==H_STA && vc==V_STA).
REQ-019 hsync active for hc in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1]; vsync active for vc in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1]; output level = POL when active, ~POL otherwise.
REQ-020 Active mode register loads `mode` only when counters are at origin (H_STA,V_STA); mid-frame mode changes have no effect until next frame.
REQ-021 frame_cnt increments by 1 when counters wrap to origin; wraps 0xFFFF -> 0.
REQ-022 Colour is all-zero whenever video_enable would be 0.
REQ-023 Mode 0 colour bars: i = index of bar, boundaries at k*HRES/8; R=~i[1], G=~i[2], B=~i[0], each bit expanded to all-ones/all-zeros (white, yellow, cyan, green, magenta, red, blue, black).
REQ-024 Mode 1 checkerboard: white when hc[CHK_LOG2]^vc[CHK_LOG2] = 1, else black.
REQ-025 Mode 2 gradient: red=hc[COLSPC-1:0], green=vc[COLSPC-1:0], blue=frame_cnt[COLSPC-1:0].
REQ-026 Mode 3 solid white (all channels all-ones).
REQ-027 Mode 4 moving box: pixel inside [bx,bx+BOX-1]x[by,by+BOX-1] white, else blue all-ones, R=G=0.
REQ-028 Box position bx,by updates at frame origin by +-1 per axis; direction flips when next step would leave [0,HRES-BOX] / [0,VRES-BOX]; flip and step occur in same update (position never out of range).
REQ-029 Modes 5-7 output black with normal timing.

Reset
REQ-030 While video_rst_n=0: hc=H_STA, vc=V_STA, active mode=0, frame_cnt=0, bx=by=0, box direction +1/+1.
REQ-031 Reset output values: sx=sy=0, video_enable=0, frame_start=line_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, colour 0.
REQ-032 First edge after release outputs sx=H_STA, sy=V_STA, frame_start=1, line_start=1; reset asserted mid-frame returns all state immediately to reset values.

Verification (HRES=16,VRES=4,H_FP=1,H_SYNC=2,H_BP=1,V_FP=V_SYNC=V_BP=1,pol=0; line 20, frame 140 clocks)
REQ-033 Release reset -> cycle 1 sx=-4,sy=-3,frame_start=1; next frame_start exactly 140 cycles later; line_start every 20 cycles.
REQ-034 Sync check -> hsync=0 only at sx=-3,-2; vsync=0 only for sy=-2; video_enable=1 exactly 64 cycles per frame.
REQ-035 mode=0 -> line sy=0: sx 0-1 all-ones RGB, sx 2-3 R,G ones B=0, sx 14-15 all zero.
REQ-036 mode changed 0->3 mid-frame -> bars continue to frame end; next frame solid white from sx=0,sy=0.
REQ-037 mode=4, BOX=2 -> bx sequence per frame 0,1,...,14,13,...; by 0,1,2,1,0; frame_cnt matches frame count.
REQ-038 Assert video_rst_n=0 at sx=5,sy=1 -> outputs zero/inactive asynchronously; after release restarts at sx=-4,sy=-3 with frame_cnt=0.
